chunked_addsub_unit: RTL and testbench

- Multi-cycle, parametrised add/subtract unit for the modified RISC datapath. Successor to the single-cycle combinational ripple adder.
- Processes a WIDTH-bit operation CHUNK bits per cycle and keeps the inter-chunk carry in a register, which bounds the carry-chain depth to CHUNK.
- Adds add-with-carry, subtract and subtract-with-borrow modes, NZCV flags, and valid/ready handshakes on input and output.

---
 rtl/chunked_addsub_unit_if.sv | 30 +++
 rtl/chunked_addsub_unit.sv | 113 +++++++++++
 tb/tb_chunked_addsub_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunked_addsub_unit_if.sv
// Request/response bundle for chunked_addsub_unit.
//   master : producer/consumer side (drives in_valid/op/a/b/carry_in/out_ready)
//   slave  : the unit (drives in_ready/out_valid/result/flags)
interface chunked_addsub_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;

  modport master (
    output in_valid, op, a, b, carry_in, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n
  );

  modport slave (
    input  in_valid, op, a, b, carry_in, out_ready,
    output in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n
  );
endinterface

// File: rtl/chunked_addsub_unit.sv
// Multi-cycle add/subtract unit: WIDTH-bit operation evaluated CHUNK bits per
// cycle with a registered inter-chunk carry, so the carry chain is CHUNK deep.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - chunked_addsub_unit_if.slave: in_valid/in_ready request handshake
//          with op (00 ADD, 01 ADC, 10 SUB, 11 SBB), a, b, carry_in;
//          out_valid/out_ready response handshake with result and NZCV flags.
module chunked_addsub_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  chunked_addsub_unit_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
      $error("chunked_addsub_unit: CHUNK must be in 1..WIDTH");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_div
      $error("chunked_addsub_unit: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // effective B (already inverted for SUB/SBB)
  logic [WIDTH-1:0] acc_q;    // working result; published to bus.result only on the last chunk
  logic             carry_q;
  logic [KW-1:0]    k_q;

  logic [WIDTH-1:0] acc_nxt;
  logic [CHUNK:0]   sum;
  logic             last;
  int               base;

  // One chunk of the ripple per cycle.
  always_comb begin
    base    = int'(k_q) * CHUNK;
    sum     = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
            + {{CHUNK{1'b0}}, carry_q};
    acc_nxt = acc_q;
    acc_nxt[base +: CHUNK] = sum[CHUNK-1:0];
    last    = (k_q == KW'(NCHUNK - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      carry_q       <= 1'b0;
      k_q           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flag_c    <= 1'b0;
      bus.flag_v    <= 1'b0;
      bus.flag_z    <= 1'b0;
      bus.flag_n    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q          <= bus.a;
            b_q          <= bus.op[1] ? ~bus.b : bus.b;
            // ADD=0, SUB=1 (two's complement +1), ADC/SBB take carry_in
            carry_q      <= bus.op[0] ? bus.carry_in : bus.op[1];
            acc_q        <= '0;
            k_q          <= '0;
            bus.in_ready <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          acc_q   <= acc_nxt;
          carry_q <= sum[CHUNK];
          k_q     <= k_q + 1'b1;
          if (last) begin
            bus.result    <= acc_nxt;
            bus.flag_c    <= sum[CHUNK];
            bus.flag_v    <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
            bus.flag_z    <= ~|acc_nxt;
            bus.flag_n    <= acc_nxt[WIDTH-1];
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_addsub_unit.sv
// Self-checking bench: three instances (CHUNK=8, 32, 1) share one stimulus
// stream; results are compared with an arithmetic reference model.
module tb_chunked_addsub_unit;
  localparam int W  = 32;
  localparam int ND = 3;

  int nch[ND] = '{4, 1, 32};
  int lat[ND];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, carry_in, out_ready;
  logic [1:0]    op;
  logic [W-1:0]  a, b;

  logic [ND-1:0] ov, ir;
  logic [W-1:0]  res[ND];
  logic [3:0]    fl[ND];   // {c, v, z, n}

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int CH = (g == 0) ? 8 : ((g == 1) ? 32 : 1);
    chunked_addsub_unit_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.op        = op;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.carry_in  = carry_in;
    assign bus.out_ready = out_ready;
    assign ov[g]  = bus.out_valid;
    assign ir[g]  = bus.in_ready;
    assign res[g] = bus.result;
    assign fl[g]  = {bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n};
    chunked_addsub_unit #(.WIDTH(W), .CHUNK(CH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   f;
  } exp_t;

  // Reference: exact integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, y,
                                 input logic ci);
    exp_t   m;
    longint ux, uy, sx, sy, t, s, cl;
    logic   c, v;
    ux = {32'h0, x};
    uy = {32'h0, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    cl = ci ? 64'sd1 : 64'sd0;
    case (o)
      2'b00:   begin t = ux + uy;            s = sx + sy;            end
      2'b01:   begin t = ux + uy + cl;       s = sx + sy + cl;       end
      2'b10:   begin t = ux - uy;            s = sx - sy;            end
      default: begin t = ux - uy - (1 - cl); s = sx - sy - (1 - cl); end
    endcase
    m.r = t[W-1:0];
    c   = o[1] ? (t >= 0) : (t >= 64'sd4294967296);
    v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    m.f = {c, v, (m.r == '0), m.r[W-1]};
    return m;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Present a request for one cycle (all units are in IDLE), then scramble
  // the inputs to prove they were latched.
  task automatic start(input logic [1:0] o, input logic [W-1:0] x, y, input logic ci);
    @(negedge clk);
    op = o; a = x; b = y; carry_in = ci; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom; carry_in = 1'($urandom);
  endtask

  // Called at the negedge following the accept edge; lat[d] = edges until out_valid.
  task automatic wait_done();
    bool_loop: begin
      for (int d = 0; d < ND; d++) lat[d] = -1;
      for (int cyc = 0; cyc < 100; cyc++) begin
        for (int d = 0; d < ND; d++) if (ov[d] === 1'b1 && lat[d] < 0) lat[d] = cyc;
        if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) disable bool_loop;
        @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL timeout waiting out_valid got=%b required=111", ov);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0; carry_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hs dut%0d in_ready=%b out_valid=%b required 1/0", d, ir[d], ov[d]);
      end
      checks++;
      if (res[d] !== '0 || fl[d] !== 4'b0) begin
        errors++;
        $display("FAIL reset_out dut%0d result=%h flags=%b required 0/0000", d, res[d], fl[d]);
      end
    end
  endtask

  task automatic test_directed();
    logic [1:0]   t_op[6] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [W-1:0] t_a[6]  = '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'h7FFF_FFFF, 32'h0000_00FF, 32'd0};
    logic [W-1:0] t_b[6]  = '{32'd1, 32'd7, 32'd5, 32'd1, 32'd0, 32'd0};
    logic         t_ci[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] t_r[6]  = '{32'h0, 32'hFFFF_FFFE, 32'd2, 32'h8000_0000, 32'h0000_0100, 32'hFFFF_FFFF};
    logic [3:0]   t_f[6]  = '{4'b1010, 4'b0001, 4'b1000, 4'b0101, 4'b0000, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      start(t_op[i], t_a[i], t_b[i], t_ci[i]);
      wait_done();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (res[d] !== t_r[i] || fl[d] !== t_f[i]) begin
          errors++;
          $display("FAIL directed%0d dut%0d result=%h flags=%b required %h/%b",
                   i, d, res[d], fl[d], t_r[i], t_f[i]);
        end
        checks++;
        if (lat[d] !== nch[d]) begin
          errors++;
          $display("FAIL directed%0d_latency dut%0d got=%0d required=%0d", i, d, lat[d], nch[d]);
        end
      end
      handshake();
    end
  endtask

  task automatic test_random();
    logic [1:0]   o;
    logic [W-1:0] x, y;
    logic         ci;
    exp_t         e;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom); x = pick(); y = pick(); ci = 1'($urandom);
      e = model(o, x, y, ci);
      start(o, x, y, ci);
      wait_done();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (res[d] !== e.r || fl[d] !== e.f || lat[d] !== nch[d]) begin
          errors++;
          $display("FAIL random%0d dut%0d op=%0d a=%h b=%h ci=%b got=%h/%b/%0d required=%h/%b/%0d",
                   i, d, o, x, y, ci, res[d], fl[d], lat[d], e.r, e.f, nch[d]);
        end
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e1, e2;
    logic [W-1:0] x;
    x  = $urandom;
    e1 = model(2'b00, x, 32'h1234_5678, 1'b0);
    e2 = model(2'b10, 32'd100, 32'd1, 1'b0);
    start(2'b00, x, 32'h1234_5678, 1'b0);
    wait_done();
    // Next request is already pending while the result is held.
    op = 2'b10; a = 32'd100; b = 32'd1; carry_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (res[d] !== e1.r || fl[d] !== e1.f || ov[d] !== 1'b1 || ir[d] !== 1'b0) begin
          errors++;
          $display("FAIL backpressure dut%0d got=%h/%b ov=%b ir=%b required=%h/%b ov=1 ir=0",
                   d, res[d], fl[d], ov[d], ir[d], e1.r, e1.f);
        end
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || ir[d] !== 1'b1 || res[d] !== e1.r) begin
        errors++;
        $display("FAIL release dut%0d ov=%b ir=%b result=%h required ov=0 ir=1 result=%h",
                 d, ov[d], ir[d], res[d], e1.r);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; a = $urandom;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ir[d] !== 1'b0) begin
        errors++;
        $display("FAIL second_accept dut%0d in_ready=%b required=0", d, ir[d]);
      end
    end
    wait_done();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (res[d] !== e2.r || fl[d] !== e2.f || lat[d] !== nch[d]) begin
        errors++;
        $display("FAIL second_op dut%0d got=%h/%b/%0d required=%h/%b/%0d",
                 d, res[d], fl[d], lat[d], e2.r, e2.f, nch[d]);
      end
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    start(2'b00, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || ir[d] !== 1'b1 || res[d] !== '0 || fl[d] !== 4'b0) begin
        errors++;
        $display("FAIL reset_mid dut%0d ov=%b ir=%b result=%h flags=%b required 0/1/0/0000",
                 d, ov[d], ir[d], res[d], fl[d]);
      end
    end
    start(2'b00, 32'd3, 32'd4, 1'b1);
    wait_done();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (res[d] !== 32'd7 || fl[d] !== 4'b0000 || lat[d] !== nch[d]) begin
        errors++;
        $display("FAIL after_reset dut%0d got=%h/%b/%0d required=00000007/0000/%0d",
                 d, res[d], fl[d], lat[d], nch[d]);
      end
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
